frame_receiver: RTL and testbench

FRAME_RECEIVER -- requirements
Module: frame_receiver

---
 rtl/frame_pkg.sv | 37 +++
 rtl/delay_timer.sv | 70 +++++++
 rtl/frame_receiver.sv | 176 +++++++++++++++++
 tb/tb_frame_receiver.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// Shared definitions for the frame_receiver / frame_sender pair: FSM encoding,
// EtherType and MAC constants, and a header byte lookup.
package frame_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_DST,
      ST_SRC,
      ST_TYPE,
      ST_PAYLOAD,
      ST_WAIT_STATUS,
      ST_DROP
   } rx_state_t;

   localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;
   localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
   localparam logic [15:0] ETH_TYPE_RARP = 16'h8035;
   localparam logic [15:0] ETH_TYPE_IPV6 = 16'h86DD;

   localparam logic [47:0] MAC_BROADCAST = '1;
   localparam logic [47:0] MAC_NETFPGA   = 48'h004E46324300;

   localparam int unsigned HDR_LEN = 14;

   // Byte idx (0..13) of the on-wire header dst|src|type, MSB first.
   function automatic logic [7:0] hdr_byte(input logic [47:0] dst,
                                           input logic [47:0] src,
                                           input logic [15:0] etype,
                                           input logic [3:0]  idx);
      logic [111:0] hdr;
      int unsigned  sel;
      hdr = {dst, src, etype};
      sel = (32'(idx) >= HDR_LEN) ? 32'd0 : (HDR_LEN - 32'd1 - 32'(idx));
      return hdr[sel*8 +: 8];
   endfunction

endpackage

// File: rtl/delay_timer.sv
// Launch-to-accept latency timer: armed by send_start, closed by frame_ok,
// disarmed with a timeout pulse when it reaches TIMEOUT.
module delay_timer #(
   parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
   input  logic        tx_clk,
   input  logic        reset,
   input  logic        send_start,
   input  logic        frame_ok,
   output logic [15:0] delay_cycles,
   output logic        delay_valid,
   output logic        delay_timeout
);

   logic [15:0] timer_q, timer_d;
   logic        armed_q, armed_d;
   logic [15:0] delay_cycles_q, delay_cycles_d;
   logic        delay_valid_q, delay_valid_d;
   logic        delay_timeout_q, delay_timeout_d;
   logic [15:0] timer_inc;

   assign timer_inc = timer_q + 16'd1;

   always_comb begin
      timer_d         = timer_q;
      armed_d         = armed_q;
      delay_cycles_d  = delay_cycles_q;
      delay_valid_d   = 1'b0;
      delay_timeout_d = 1'b0;
      if (armed_q) begin
         if (frame_ok) begin
            delay_cycles_d = timer_inc;
            delay_valid_d  = 1'b1;
            armed_d        = 1'b0;
         end else begin
            timer_d = timer_inc;
            if (timer_inc == TIMEOUT) begin
               delay_timeout_d = 1'b1;
               armed_d         = 1'b0;
            end
         end
      end
      // A launch is applied after any closing measurement in the same cycle.
      if (send_start) begin
         timer_d = '0;
         armed_d = 1'b1;
      end
   end

   always_ff @(posedge tx_clk or posedge reset) begin
      if (reset) begin
         timer_q         <= '0;
         armed_q         <= 1'b0;
         delay_cycles_q  <= '0;
         delay_valid_q   <= 1'b0;
         delay_timeout_q <= 1'b0;
      end else begin
         timer_q         <= timer_d;
         armed_q         <= armed_d;
         delay_cycles_q  <= delay_cycles_d;
         delay_valid_q   <= delay_valid_d;
         delay_timeout_q <= delay_timeout_d;
      end
   end

   assign delay_cycles  = delay_cycles_q;
   assign delay_valid   = delay_valid_q;
   assign delay_timeout = delay_timeout_q;

endmodule

// File: rtl/frame_receiver.sv
// Ethernet frame filter/acceptor with launch-to-accept latency measurement.
// Define FRAME_RECEIVER_SRC_CHECK_EN to also check the source MAC.
module frame_receiver
   import frame_pkg::*;
#(
   parameter logic [47:0] EXP_DST_MAC  = MAC_BROADCAST,
   parameter logic [47:0] EXP_SRC_MAC  = MAC_NETFPGA,
   parameter logic [15:0] EXP_ETH_TYPE = ETH_TYPE_ARP,
   parameter int unsigned MIN_LEN      = 60,
   parameter logic [15:0] TIMEOUT      = 16'hFFFF
) (
   input  logic        tx_clk,
   input  logic        reset,
   input  logic [7:0]  mac_rx_data,
   input  logic        mac_rx_dvld,
   input  logic        mac_rx_goodframe,
   input  logic        mac_rx_badframe,
   input  logic        send_start,
   output logic        rx_frame_ok,
   output logic        rx_frame_err,
   output logic [15:0] delay_cycles,
   output logic        delay_valid,
   output logic        delay_timeout,
   output logic [15:0] frame_count,
   output logic [15:0] err_count
);

`ifdef FRAME_RECEIVER_SRC_CHECK_EN
   localparam bit SRC_CHECK = 1'b1;
`else
   localparam bit SRC_CHECK = 1'b0;
`endif

   rx_state_t   state_q, state_d;
   logic [13:0] byte_cnt_q, byte_cnt_d;
   logic        mismatch_q, mismatch_d;
   logic        trunc_q, trunc_d;
   logic        dvld_prev_q, dvld_prev_d;
   logic        rx_frame_ok_q, rx_frame_ok_d;
   logic        rx_frame_err_q, rx_frame_err_d;
   logic [15:0] frame_count_q, frame_count_d;
   logic [15:0] err_count_q, err_count_d;

   logic        dvld_rise, status, start_frame, is_src_byte, byte_bad;
   logic        len_ok, frame_good;
   logic [3:0]  hdr_idx;
   logic [13:0] byte_cnt_inc;

   assign dvld_rise   = mac_rx_dvld & ~dvld_prev_q;
   assign status      = mac_rx_goodframe | mac_rx_badframe;
   assign start_frame = dvld_rise & ((state_q == ST_IDLE) || (state_q == ST_WAIT_STATUS) ||
                                     (state_q == ST_DROP));
   assign hdr_idx     = start_frame ? 4'd0 : byte_cnt_q[3:0];
   assign is_src_byte = (hdr_idx >= 4'd6) && (hdr_idx <= 4'd11);
   assign byte_bad    = (mac_rx_data != hdr_byte(EXP_DST_MAC, EXP_SRC_MAC, EXP_ETH_TYPE, hdr_idx))
                        && (SRC_CHECK || !is_src_byte);
   assign byte_cnt_inc = (byte_cnt_q == '1) ? byte_cnt_q : byte_cnt_q + 14'd1;
   assign len_ok      = 32'(byte_cnt_q) >= MIN_LEN;
   assign frame_good  = mac_rx_goodframe & ~mac_rx_badframe & ~mismatch_q & len_ok;

   always_ff @(posedge tx_clk or posedge reset) begin
      if (reset) begin
         state_q        <= ST_IDLE;
         byte_cnt_q     <= '0;
         mismatch_q     <= 1'b0;
         trunc_q        <= 1'b0;
         // Held high so a frame already in flight at reset release is not seen as a start.
         dvld_prev_q    <= 1'b1;
         rx_frame_ok_q  <= 1'b0;
         rx_frame_err_q <= 1'b0;
         frame_count_q  <= '0;
         err_count_q    <= '0;
      end else begin
         state_q        <= state_d;
         byte_cnt_q     <= byte_cnt_d;
         mismatch_q     <= mismatch_d;
         trunc_q        <= trunc_d;
         dvld_prev_q    <= dvld_prev_d;
         rx_frame_ok_q  <= rx_frame_ok_d;
         rx_frame_err_q <= rx_frame_err_d;
         frame_count_q  <= frame_count_d;
         err_count_q    <= err_count_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      byte_cnt_d  = byte_cnt_q;
      mismatch_d  = mismatch_q;
      trunc_d     = trunc_q;
      dvld_prev_d = mac_rx_dvld;
      if (start_frame) begin
         state_d    = ST_DST;
         byte_cnt_d = 14'd1;
         mismatch_d = byte_bad;
         trunc_d    = 1'b0;
      end else begin
         case (state_q)
            ST_DST, ST_SRC, ST_TYPE: begin
               if (mac_rx_dvld) begin
                  byte_cnt_d = byte_cnt_inc;
                  mismatch_d = mismatch_q | byte_bad;
                  if (state_q == ST_DST && byte_cnt_q == 14'd5)
                     state_d = ST_SRC;
                  else if (state_q == ST_SRC && byte_cnt_q == 14'd11)
                     state_d = ST_TYPE;
                  else if (state_q == ST_TYPE && byte_cnt_q == 14'd13)
                     state_d = ST_PAYLOAD;
               end else begin
                  trunc_d = 1'b1;
                  state_d = status ? ST_IDLE : ST_DROP;
               end
            end
            ST_PAYLOAD: begin
               if (mac_rx_dvld)
                  byte_cnt_d = byte_cnt_inc;
               else
                  state_d = status ? ST_IDLE : ST_WAIT_STATUS;
            end
            ST_WAIT_STATUS, ST_DROP: begin
               if (status)
                  state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // The status pulse may coincide with the first dvld-low cycle, so the verdict
   // is taken there as well as in WAIT_STATUS/DROP.
   always_comb begin
      rx_frame_ok_d  = 1'b0;
      rx_frame_err_d = 1'b0;
      case (state_q)
         ST_DST, ST_SRC, ST_TYPE: begin
            if (!mac_rx_dvld && status)
               rx_frame_err_d = 1'b1;
         end
         ST_PAYLOAD: begin
            if (!mac_rx_dvld && status) begin
               rx_frame_ok_d  = frame_good;
               rx_frame_err_d = ~frame_good;
            end
         end
         ST_WAIT_STATUS, ST_DROP: begin
            if (status) begin
               rx_frame_ok_d  = frame_good & ~trunc_q;
               rx_frame_err_d = ~(frame_good & ~trunc_q);
            end else if (dvld_rise) begin
               rx_frame_err_d = 1'b1;
            end
         end
         default: ;
      endcase
      frame_count_d = frame_count_q + {15'd0, rx_frame_ok_d};
      err_count_d   = err_count_q + {15'd0, rx_frame_err_d};
   end

   delay_timer #(
      .TIMEOUT(TIMEOUT)
   ) u_delay_timer (
      .tx_clk        (tx_clk),
      .reset         (reset),
      .send_start    (send_start),
      .frame_ok      (rx_frame_ok_q),
      .delay_cycles  (delay_cycles),
      .delay_valid   (delay_valid),
      .delay_timeout (delay_timeout)
   );

   assign rx_frame_ok  = rx_frame_ok_q;
   assign rx_frame_err = rx_frame_err_q;
   assign frame_count  = frame_count_q;
   assign err_count    = err_count_q;

endmodule

// File: tb/tb_frame_receiver.sv
// Directed, scoreboard-checked bench for frame_receiver: frame verdicts,
// counters, latency measurement, timeout and mid-frame reset.
module tb_frame_receiver;

   logic        tx_clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  mac_rx_data = '0;
   logic        mac_rx_dvld = 1'b0;
   logic        mac_rx_goodframe = 1'b0;
   logic        mac_rx_badframe = 1'b0;
   logic        send_start = 1'b0;
   logic        send_start2 = 1'b0;

   logic        rx_frame_ok, rx_frame_err, delay_valid, delay_timeout;
   logic [15:0] delay_cycles, frame_count, err_count;
   logic        to_ok, to_err, to_valid, to_timeout;
   logic [15:0] to_cycles, to_fcount, to_ecount;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [1:0]  exp_q[$];
   int          dly_q[$];
   logic [7:0]  fbuf [0:255];

   localparam logic [1:0] EXP_OK  = 2'b10;
   localparam logic [1:0] EXP_ERR = 2'b01;

   always #5 tx_clk = ~tx_clk;

   frame_receiver dut (
      .tx_clk           (tx_clk),
      .reset            (reset),
      .mac_rx_data      (mac_rx_data),
      .mac_rx_dvld      (mac_rx_dvld),
      .mac_rx_goodframe (mac_rx_goodframe),
      .mac_rx_badframe  (mac_rx_badframe),
      .send_start       (send_start),
      .rx_frame_ok      (rx_frame_ok),
      .rx_frame_err     (rx_frame_err),
      .delay_cycles     (delay_cycles),
      .delay_valid      (delay_valid),
      .delay_timeout    (delay_timeout),
      .frame_count      (frame_count),
      .err_count        (err_count)
   );

   frame_receiver #(
      .TIMEOUT(16'd50)
   ) dut_to (
      .tx_clk           (tx_clk),
      .reset            (reset),
      .mac_rx_data      (8'h00),
      .mac_rx_dvld      (1'b0),
      .mac_rx_goodframe (1'b0),
      .mac_rx_badframe  (1'b0),
      .send_start       (send_start2),
      .rx_frame_ok      (to_ok),
      .rx_frame_err     (to_err),
      .delay_cycles     (to_cycles),
      .delay_valid      (to_valid),
      .delay_timeout    (to_timeout),
      .frame_count      (to_fcount),
      .err_count        (to_ecount)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge tx_clk);
      #1;
   endtask

   task automatic build(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] et);
      logic [111:0] h;
      h = {dst, src, et};
      for (int i = 0; i < 14; i++) fbuf[i] = h[(13 - i)*8 +: 8];
      for (int i = 14; i < 256; i++) fbuf[i] = 8'(i);
   endtask

   // status: 0 none, 1 goodframe, 2 badframe; gap = idle cycles before status.
   task automatic drive_frame(input int len, input int gap, input int status);
      for (int i = 0; i < len; i++) begin
         mac_rx_dvld = 1'b1;
         mac_rx_data = fbuf[i];
         tick();
      end
      mac_rx_dvld = 1'b0;
      mac_rx_data = '0;
      repeat (gap) tick();
      mac_rx_goodframe = (status == 1);
      mac_rx_badframe  = (status == 2);
      tick();
      mac_rx_goodframe = 1'b0;
      mac_rx_badframe  = 1'b0;
      repeat (4) tick();
   endtask

   task automatic drain(input logic [15:0] fc, input logic [15:0] ec);
      for (int i = 0; i < 20 && (exp_q.size() != 0 || dly_q.size() != 0); i++) tick();
      chk("sb_frames_left", exp_q.size(), 0);
      chk("sb_delays_left", dly_q.size(), 0);
      chk("frame_count", frame_count, fc);
      chk("err_count", err_count, ec);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ok"}, rx_frame_ok, 0);
      chk({tag, "_err"}, rx_frame_err, 0);
      chk({tag, "_dcycles"}, delay_cycles, 0);
      chk({tag, "_dvalid"}, delay_valid, 0);
      chk({tag, "_dtimeout"}, delay_timeout, 0);
      chk({tag, "_fcount"}, frame_count, 0);
      chk({tag, "_ecount"}, err_count, 0);
   endtask

   always @(posedge tx_clk) begin
      #1;
      if (!reset) begin
         if (rx_frame_ok || rx_frame_err) begin
            if (exp_q.size() == 0) chk("unexpected_verdict", {rx_frame_ok, rx_frame_err}, 0);
            else chk("frame_verdict", {rx_frame_ok, rx_frame_err}, exp_q.pop_front());
         end
         if (delay_valid) begin
            if (dly_q.size() == 0) chk("unexpected_delay_valid", delay_valid, 0);
            else chk("delay_cycles", delay_cycles, dly_q.pop_front());
         end
         if (delay_timeout) chk("unexpected_delay_timeout", delay_timeout, 0);
         if (to_valid) chk("to_unexpected_valid", to_valid, 0);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: observed no finish, expected finish before time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) tick();
      chk_all_zero("reset");
      reset = 1'b0;
      repeat (2) tick();

      // Good broadcast ARP frame, minimum length.
      build(48'hFFFFFFFFFFFF, 48'h004E46324300, 16'h0806);
      exp_q.push_back(EXP_OK);
      drive_frame(60, 0, 1);
      drain(16'd1, 16'd0);

      // Destination byte 3 wrong.
      fbuf[3] = 8'h00;
      exp_q.push_back(EXP_ERR);
      drive_frame(60, 0, 1);
      drain(16'd1, 16'd1);

      // Runts: 40 bytes and one short of the minimum.
      build(48'hFFFFFFFFFFFF, 48'h004E46324300, 16'h0806);
      exp_q.push_back(EXP_ERR);
      drive_frame(40, 0, 1);
      drain(16'd1, 16'd2);
      exp_q.push_back(EXP_ERR);
      drive_frame(59, 0, 1);
      drain(16'd1, 16'd3);

      // Bad FCS.
      exp_q.push_back(EXP_ERR);
      drive_frame(60, 0, 2);
      drain(16'd1, 16'd4);

      // Truncated in the source field, status arrives late.
      exp_q.push_back(EXP_ERR);
      drive_frame(8, 2, 1);
      drain(16'd1, 16'd5);

      // Wrong EtherType.
      build(48'hFFFFFFFFFFFF, 48'h004E46324300, 16'h0800);
      exp_q.push_back(EXP_ERR);
      drive_frame(60, 0, 1);
      drain(16'd1, 16'd6);

      // Missing status, next frame starts: error then acceptance.
      build(48'hFFFFFFFFFFFF, 48'h004E46324300, 16'h0806);
      exp_q.push_back(EXP_ERR);
      exp_q.push_back(EXP_OK);
      drive_frame(60, 0, 0);
      drive_frame(60, 0, 1);
      drain(16'd2, 16'd7);

      // Latency: launch at edge s, frame bytes from edge s+139, verdict at s+200.
      send_start = 1'b1;
      tick();
      send_start = 1'b0;
      repeat (138) tick();
      exp_q.push_back(EXP_OK);
      dly_q.push_back(200);
      drive_frame(60, 0, 1);
      drain(16'd3, 16'd7);

      // Timeout on the TIMEOUT=50 instance with no frame.
      send_start2 = 1'b1;
      tick();
      send_start2 = 1'b0;
      repeat (48) tick();
      tick();
      chk("timeout_early", to_timeout, 0);
      tick();
      chk("timeout_pulse", to_timeout, 1);
      chk("timeout_no_valid", to_valid, 0);
      tick();
      chk("timeout_one_cycle", to_timeout, 0);
      chk("timeout_cycles_untouched", to_cycles, 0);

      // Reset at byte 10 of a frame; the remainder must be ignored.
      for (int i = 0; i < 10; i++) begin
         mac_rx_dvld = 1'b1;
         mac_rx_data = fbuf[i];
         tick();
      end
      reset = 1'b1;
      mac_rx_data = fbuf[10];
      #1;
      chk("async_reset_fcount", frame_count, 0);
      chk("async_reset_ecount", err_count, 0);
      tick();
      chk_all_zero("midreset");
      reset = 1'b0;
      for (int i = 11; i < 60; i++) begin
         mac_rx_data = fbuf[i];
         tick();
      end
      mac_rx_dvld = 1'b0;
      mac_rx_data = '0;
      mac_rx_goodframe = 1'b1;
      tick();
      mac_rx_goodframe = 1'b0;
      repeat (4) tick();
      drain(16'd0, 16'd0);
      exp_q.push_back(EXP_OK);
      drive_frame(60, 0, 1);
      drain(16'd1, 16'd0);
      chk("to_instance_fcount", to_fcount, 0);
      chk("to_instance_ecount", to_ecount, 0);
      chk("to_instance_verdicts", {to_ok, to_err}, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
